// File: rtl/switch_input_port.sv
// switch_input_port: synchronises the switch bank and ENTER, debounces ENTER,
// and captures the switch word on each debounced press behind a valid/rd handshake.
module switch_input_port #(
  parameter int WORD_W     = 8,
  parameter int DEBOUNCE_N = 4
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] switches,
  input  logic              enter,
  input  logic              rd,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  output logic              overrun,
  output logic [WORD_W-1:0] sw_live
);
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t            state;
  logic [WORD_W-1:0] sw_s1;
  logic              en_s1;
  logic              enter_s;
  logic              db_level;
  logic [CNT_W-1:0]  cnt;
  logic              done;
  logic              capture;
  always_comb begin
    done    = (enter_s != db_level) && (cnt == CNT_W'(DEBOUNCE_N - 1));
    capture = done && !db_level;
  end
  assign valid = (state == FULL);
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      sw_s1    <= '0;
      sw_live  <= '0;
      en_s1    <= 1'b0;
      enter_s  <= 1'b0;
      cnt      <= '0;
      db_level <= 1'b0;
      data     <= '0;
      overrun  <= 1'b0;
      state    <= EMPTY;
    end else begin
      sw_s1   <= switches;
      sw_live <= sw_s1;
      en_s1   <= enter;
      enter_s <= en_s1;
      cnt     <= (enter_s == db_level || done) ? '0 : cnt + 1'b1;
      if (done) db_level <= enter_s;
      // Only the rising debounced edge captures; a held word blocks new ones.
      if (state == EMPTY) begin
        if (capture) begin
          data  <= sw_live;
          state <= FULL;
        end
      end else if (rd) begin
        overrun <= 1'b0;
        if (capture) data <= sw_live;
        else state <= EMPTY;
      end else if (capture) begin
        overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_switch_input_port.sv
// tb_switch_input_port: directed checks of sync, debounce, capture and handshake.
module tb_switch_input_port;
  logic       clock = 1'b0;
  logic       n_reset;
  logic [7:0] switches;
  logic       enter;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       overrun;
  logic [7:0] sw_live;
  int         passed = 0;
  int         total = 0;

  switch_input_port #(.WORD_W(8), .DEBOUNCE_N(4)) dut (
    .clock(clock), .n_reset(n_reset), .switches(switches), .enter(enter),
    .rd(rd), .data(data), .valid(valid), .overrun(overrun), .sw_live(sw_live)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    n_reset = 1'b0; enter = 1'b1; switches = 8'hFF; rd = 1'b0;
    tick(1);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sw_live", sw_live, 0);
    n_reset = 1'b1; enter = 1'b0; switches = 8'h05;
    tick(4);
    enter = 1'b1;
    tick(5);
    check("press_early_valid", valid, 0);
    tick(1);
    check("press_valid", valid, 1);
    check("press_data", data, 8'h05);
    tick(4);
    check("held_one_capture_overrun", overrun, 0);
    enter = 1'b0;
    rd = 1'b1; tick(1); rd = 1'b0;
    check("rd_valid", valid, 0);
    check("rd_data_kept", data, 8'h05);
    tick(8);
    enter = 1'b1; tick(3); enter = 1'b0; tick(8);
    check("short_pulse_valid", valid, 0);
    enter = 1'b1; tick(3); enter = 1'b0; tick(1); enter = 1'b1; tick(2); enter = 1'b0; tick(8);
    check("glitch_press_valid", valid, 0);
    enter = 1'b1; tick(6);
    check("cap1_valid", valid, 1);
    check("cap1_data", data, 8'h05);
    enter = 1'b0; tick(8);
    switches = 8'h03; tick(3);
    enter = 1'b1; tick(6);
    check("ovr_data_kept", data, 8'h05);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", valid, 1);
    enter = 1'b0; tick(8);
    rd = 1'b1; tick(1);
    check("ovr_rd_valid", valid, 0);
    check("ovr_rd_overrun", overrun, 0);
    tick(1); rd = 1'b0;
    check("empty_rd_valid", valid, 0);
    check("empty_rd_data", data, 8'h05);
    check("empty_rd_overrun", overrun, 0);
    switches = 8'h05; tick(3);
    enter = 1'b1; tick(6);
    check("full5_data", data, 8'h05);
    enter = 1'b0; tick(8);
    switches = 8'h03; tick(3);
    enter = 1'b1; tick(5);
    check("pre_same_edge_data", data, 8'h05);
    rd = 1'b1; tick(1); rd = 1'b0;
    check("same_edge_data", data, 8'h03);
    check("same_edge_valid", valid, 1);
    check("same_edge_overrun", overrun, 0);
    enter = 1'b0; tick(8);
    switches = 8'h05; tick(3);
    check("live_5", sw_live, 8'h05);
    switches = 8'h03; tick(1);
    check("live_lag1", sw_live, 8'h05);
    tick(1);
    check("live_3", sw_live, 8'h03);
    check("live_data_unchanged", data, 8'h03);
    check("live_valid_unchanged", valid, 1);
    n_reset = 1'b0; enter = 1'b1; switches = 8'h09; tick(1);
    check("rst2_valid", valid, 0);
    check("rst2_data", data, 0);
    n_reset = 1'b1; tick(5);
    check("rst_held_early_valid", valid, 0);
    tick(1);
    check("rst_held_valid", valid, 1);
    check("rst_held_data", data, 8'h09);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
